// File: rtl/preamble_lock_ctrl.sv
// preamble_lock_ctrl: sequencer for the ADC preamble detector.
//   Arms a detection run, waits out the averager monitor window, searches for a
//   preamble lock under an optional timeout and, once locked, forwards a fixed
//   number of aligned beats downstream with tlast. Every run ends with a detector
//   clear pulse.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_start, i_abort               run control pulses
//   i_cfg_*                        run configuration, latched on an accepted start
//   o_det_state_changed            clear pulse to the detector
//   o_det_*_cycle_length           latched monitor/preamble lengths for the detector
//   i_det_tdata/tvalid/matched_pattern  aligned detector output
//   o_m_tdata/tvalid/tlast         payload stream (no backpressure)
//   o_busy, o_locked, o_lock_pattern    run status
//   o_timeout_err, o_realign_err   sticky error flags, cleared on an accepted start
//   o_run_count                    completed runs (wraps)
module preamble_lock_ctrl #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned TO_WIDTH   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [15:0]           i_cfg_monitor_cycles,
  input  logic [15:0]           i_cfg_preamble_cycles,
  input  logic [15:0]           i_cfg_payload_cycles,
  input  logic [TO_WIDTH-1:0]   i_cfg_timeout_cycles,
  output logic                  o_det_state_changed,
  output logic [15:0]           o_det_monitor_cycle_length,
  output logic [15:0]           o_det_preamble_cycle_length,
  input  logic [DATA_WIDTH-1:0] i_det_tdata,
  input  logic                  i_det_tvalid,
  input  logic [15:0]           i_det_matched_pattern,
  output logic [DATA_WIDTH-1:0] o_m_tdata,
  output logic                  o_m_tvalid,
  output logic                  o_m_tlast,
  output logic                  o_busy,
  output logic                  o_locked,
  output logic [15:0]           o_lock_pattern,
  output logic                  o_timeout_err,
  output logic                  o_realign_err,
  output logic [15:0]           o_run_count
);

  typedef enum logic [2:0] {
    StIdle, StArm, StMonitor, StSearch, StLocked, StDone
  } state_e;

  localparam logic [TO_WIDTH-1:0] ToOne = TO_WIDTH'(1);

  state_e                r_state;
  logic                  r_state_changed;
  logic [15:0]           r_mon_len;
  logic [15:0]           r_pre_len;
  logic [15:0]           r_pay_len;
  logic [TO_WIDTH-1:0]   r_to_len;
  logic [15:0]           r_mon_cnt;
  logic [TO_WIDTH-1:0]   r_to_cnt;
  logic [15:0]           r_beat_cnt;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;
  logic                  r_busy;
  logic                  r_locked;
  logic [15:0]           r_lock_pattern;
  logic                  r_timeout_err;
  logic                  r_realign_err;
  logic [15:0]           r_run_count;

  logic [TO_WIDTH-1:0]   w_to_next;
  logic [15:0]           w_beat_next;
  logic                  w_lock_hit;

  assign w_to_next   = r_to_cnt + ToOne;
  assign w_beat_next = r_beat_cnt + 16'd1;
  assign w_lock_hit  = i_det_tvalid && (i_det_matched_pattern != 16'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= StIdle;
      r_state_changed <= 1'b0;
      r_mon_len       <= '0;
      r_pre_len       <= '0;
      r_pay_len       <= '0;
      r_to_len        <= '0;
      r_mon_cnt       <= '0;
      r_to_cnt        <= '0;
      r_beat_cnt      <= '0;
      r_m_tdata       <= '0;
      r_m_tvalid      <= 1'b0;
      r_m_tlast       <= 1'b0;
      r_busy          <= 1'b0;
      r_locked        <= 1'b0;
      r_lock_pattern  <= '0;
      r_timeout_err   <= 1'b0;
      r_realign_err   <= 1'b0;
      r_run_count     <= '0;
    end else begin
      // Single-cycle strobes default low.
      r_state_changed <= 1'b0;
      r_m_tvalid      <= 1'b0;
      r_m_tlast       <= 1'b0;
      if (r_state != StIdle && i_abort) begin
        // Abort overrides everything: no beat forwarded, run not counted.
        r_state         <= StIdle;
        r_state_changed <= 1'b1;
        r_busy          <= 1'b0;
        r_locked        <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_start && !i_abort) begin
              r_mon_len       <= i_cfg_monitor_cycles;
              r_pre_len       <= i_cfg_preamble_cycles;
              r_pay_len       <= i_cfg_payload_cycles;
              r_to_len        <= i_cfg_timeout_cycles;
              r_timeout_err   <= 1'b0;
              r_realign_err   <= 1'b0;
              r_state         <= StArm;
              r_state_changed <= 1'b1;
              r_busy          <= 1'b1;
            end
          end
          StArm: begin
            r_mon_cnt <= '0;
            r_to_cnt  <= '0;
            r_state   <= (r_mon_len != 16'd0) ? StMonitor : StSearch;
          end
          StMonitor: begin
            // r_mon_len is nonzero here, so the window is exactly r_mon_len cycles.
            if (r_mon_cnt == r_mon_len - 16'd1) begin
              r_state <= StSearch;
            end else begin
              r_mon_cnt <= r_mon_cnt + 16'd1;
            end
          end
          StSearch: begin
            r_to_cnt <= w_to_next;
            if (w_lock_hit) begin
              // Lock beats a same-cycle timeout; the lock beat is payload beat 1.
              r_lock_pattern <= i_det_matched_pattern;
              if (r_pay_len == 16'd0) begin
                r_state         <= StDone;
                r_state_changed <= 1'b1;
              end else begin
                r_m_tdata  <= i_det_tdata;
                r_m_tvalid <= 1'b1;
                r_beat_cnt <= 16'd1;
                if (r_pay_len == 16'd1) begin
                  r_m_tlast       <= 1'b1;
                  r_state         <= StDone;
                  r_state_changed <= 1'b1;
                end else begin
                  r_state  <= StLocked;
                  r_locked <= 1'b1;
                end
              end
            end else if (r_to_len != '0 && w_to_next == r_to_len) begin
              r_timeout_err   <= 1'b1;
              r_state         <= StDone;
              r_state_changed <= 1'b1;
            end
          end
          StLocked: begin
            if (i_det_tvalid) begin
              if (i_det_matched_pattern == r_lock_pattern) begin
                r_m_tdata  <= i_det_tdata;
                r_m_tvalid <= 1'b1;
                r_beat_cnt <= w_beat_next;
                if (w_beat_next == r_pay_len) begin
                  r_m_tlast       <= 1'b1;
                  r_state         <= StDone;
                  r_state_changed <= 1'b1;
                  r_locked        <= 1'b0;
                end
              end else begin
                // Alignment moved under us: drop the beat and re-arm the detector.
                r_realign_err   <= 1'b1;
                r_beat_cnt      <= '0;
                r_state         <= StArm;
                r_state_changed <= 1'b1;
                r_locked        <= 1'b0;
              end
            end
          end
          StDone: begin
            if (!r_timeout_err) r_run_count <= r_run_count + 16'd1;
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_det_state_changed         = r_state_changed;
  assign o_det_monitor_cycle_length  = r_mon_len;
  assign o_det_preamble_cycle_length = r_pre_len;
  assign o_m_tdata                   = r_m_tdata;
  assign o_m_tvalid                  = r_m_tvalid;
  assign o_m_tlast                   = r_m_tlast;
  assign o_busy                      = r_busy;
  assign o_locked                    = r_locked;
  assign o_lock_pattern              = r_lock_pattern;
  assign o_timeout_err               = r_timeout_err;
  assign o_realign_err               = r_realign_err;
  assign o_run_count                 = r_run_count;

endmodule

// File: tb/tb_preamble_lock_ctrl.sv
// Directed testbench for preamble_lock_ctrl. Inputs change 1 ns after a rising
// edge; registered outputs are checked at the same point.
module tb_preamble_lock_ctrl;
  localparam int unsigned DW = 256;
  localparam int unsigned TW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   cfg_mon = '0, cfg_pre = '0, cfg_pay = '0;
  logic [TW-1:0] cfg_to = '0;
  logic [DW-1:0] det_tdata = '0;
  logic          det_tvalid = 1'b0;
  logic [15:0]   det_pat = '0;

  logic          det_sc;
  logic [15:0]   det_mon_len, det_pre_len;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, busy, locked, timeout_err, realign_err;
  logic [15:0]   lock_pattern, run_count;

  int errors = 0;
  int checks = 0;
  int n_beats = 0;
  int n_last = 0;
  int b0, l0;

  preamble_lock_ctrl #(.DATA_WIDTH(DW), .TO_WIDTH(TW)) dut (
    .i_clk                       (clk),
    .i_rst_n                     (rst_n),
    .i_start                     (start),
    .i_abort                     (abort),
    .i_cfg_monitor_cycles        (cfg_mon),
    .i_cfg_preamble_cycles       (cfg_pre),
    .i_cfg_payload_cycles        (cfg_pay),
    .i_cfg_timeout_cycles        (cfg_to),
    .o_det_state_changed         (det_sc),
    .o_det_monitor_cycle_length  (det_mon_len),
    .o_det_preamble_cycle_length (det_pre_len),
    .i_det_tdata                 (det_tdata),
    .i_det_tvalid                (det_tvalid),
    .i_det_matched_pattern       (det_pat),
    .o_m_tdata                   (m_tdata),
    .o_m_tvalid                  (m_tvalid),
    .o_m_tlast                   (m_tlast),
    .o_busy                      (busy),
    .o_locked                    (locked),
    .o_lock_pattern              (lock_pattern),
    .o_timeout_err               (timeout_err),
    .o_realign_err               (realign_err),
    .o_run_count                 (run_count)
  );

  always #5 clk = ~clk;

  // Running tallies of forwarded beats and tlasts, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_tvalid) n_beats++;
    if (m_tlast) n_last++;
  end

  function automatic logic [DW-1:0] beat(input int k);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(k);
    return {8{w}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) step();
  endtask

  task automatic drive_det(input logic v, input logic [15:0] p, input logic [DW-1:0] d);
    det_tvalid = v;
    det_pat    = p;
    det_tdata  = d;
  endtask

  // Returns just after the accepting edge, i.e. while the FSM is in ARM.
  task automatic start_run(input logic [15:0] mon, input logic [15:0] pre,
                           input logic [15:0] pay, input logic [TW-1:0] to);
    cfg_mon = mon; cfg_pre = pre; cfg_pay = pay; cfg_to = to;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if ({det_sc, m_tvalid, m_tlast, busy, locked, timeout_err, realign_err} !== 7'd0) begin
      errors++; $display("FAIL reset_flags: got %b want 0", {det_sc, m_tvalid, m_tlast, busy, locked, timeout_err, realign_err}); end
    checks++; if ({run_count, lock_pattern, det_mon_len, det_pre_len} !== 64'd0) begin
      errors++; $display("FAIL reset_counts: got %h want 0", {run_count, lock_pattern, det_mon_len, det_pre_len}); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_run();
    b0 = n_beats; l0 = n_last;
    start_run(16'd4, 16'd8, 16'd3, 100);
    checks++; if ({det_sc, busy} !== 2'b11) begin errors++; $display("FAIL basic_arm: sc,busy=%b want 11", {det_sc, busy}); end
    checks++; if ({det_mon_len, det_pre_len} !== {16'd4, 16'd8}) begin errors++; $display("FAIL basic_cfg_latch: got %h want 00040008", {det_mon_len, det_pre_len}); end
    // ARM + 4 monitor cycles with a "lock" present must be ignored.
    drive_det(1'b1, 16'hAAAA, beat(99));
    step();
    checks++; if (det_sc !== 1'b0) begin errors++; $display("FAIL basic_sc_width: got %b want 0", det_sc); end
    cyc(4);
    checks++; if ({locked, m_tvalid} !== 2'b00) begin errors++; $display("FAIL basic_monitor_ignore: locked,tvalid=%b want 00", {locked, m_tvalid}); end
    drive_det(1'b1, 16'h0000, beat(98));
    cyc(9);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL basic_no_early_lock: got %b want 0", locked); end
    drive_det(1'b1, 16'h01FE, beat(1));
    step();
    checks++; if ({locked, m_tvalid, m_tlast} !== 3'b110) begin errors++; $display("FAIL basic_lock: locked,tvalid,tlast=%b want 110", {locked, m_tvalid, m_tlast}); end
    checks++; if (m_tdata !== beat(1)) begin errors++; $display("FAIL basic_beat1_data: got %h want %h", m_tdata, beat(1)); end
    checks++; if (lock_pattern !== 16'h01FE) begin errors++; $display("FAIL basic_lock_pattern: got %h want 01fe", lock_pattern); end
    drive_det(1'b1, 16'h01FE, beat(2));
    step();
    drive_det(1'b0, 16'h01FE, beat(50));
    step();
    checks++; if ({m_tvalid, m_tdata} !== {1'b0, beat(2)}) begin errors++; $display("FAIL basic_gap_hold: tvalid=%b data=%h want 0 %h", m_tvalid, m_tdata, beat(2)); end
    drive_det(1'b1, 16'h01FE, beat(3));
    step();
    checks++; if ({m_tvalid, m_tlast, det_sc, locked} !== 4'b1110) begin errors++; $display("FAIL basic_last: tvalid,tlast,sc,locked=%b want 1110", {m_tvalid, m_tlast, det_sc, locked}); end
    drive_det(1'b0, 16'h0, beat(0));
    step();
    checks++; if ({busy, run_count} !== {1'b0, 16'd1}) begin errors++; $display("FAIL basic_done: busy=%b run_count=%0d want 0 1", busy, run_count); end
    checks++; if ((n_beats - b0) != 3 || (n_last - l0) != 1) begin errors++; $display("FAIL basic_beat_total: beats=%0d lasts=%0d want 3 1", n_beats - b0, n_last - l0); end
  endtask

  task automatic test_no_monitor();
    start_run(16'd0, 16'd8, 16'd2, 50);
    drive_det(1'b1, 16'h01FE, beat(11));
    step();
    checks++; if ({locked, m_tvalid, det_sc} !== 3'b000) begin errors++; $display("FAIL nomon_arm_ignore: locked,tvalid,sc=%b want 000", {locked, m_tvalid, det_sc}); end
    step();
    checks++; if ({locked, m_tvalid, m_tdata} !== {2'b11, beat(11)}) begin errors++; $display("FAIL nomon_first_search_lock: locked,tvalid=%b data=%h", {locked, m_tvalid}, m_tdata); end
    drive_det(1'b1, 16'h01FE, beat(12));
    step();
    checks++; if ({m_tlast, det_sc} !== 2'b11) begin errors++; $display("FAIL nomon_last: tlast,sc=%b want 11", {m_tlast, det_sc}); end
    drive_det(1'b0, 16'h0, beat(0));
    step();
    checks++; if (run_count !== 16'd2) begin errors++; $display("FAIL nomon_run_count: got %0d want 2", run_count); end
  endtask

  task automatic test_timeout();
    b0 = n_beats;
    start_run(16'd0, 16'd8, 16'd4, 20);
    drive_det(1'b1, 16'h0000, beat(7));
    cyc(20);
    checks++; if ({timeout_err, busy, det_sc} !== 3'b010) begin errors++; $display("FAIL to_before: err,busy,sc=%b want 010", {timeout_err, busy, det_sc}); end
    step();
    checks++; if ({timeout_err, det_sc} !== 2'b11) begin errors++; $display("FAIL to_fire: err,sc=%b want 11", {timeout_err, det_sc}); end
    drive_det(1'b0, 16'h0, beat(0));
    step();
    checks++; if ({busy, timeout_err, run_count} !== {2'b01, 16'd2}) begin errors++; $display("FAIL to_after: busy=%b err=%b run_count=%0d want 0 1 2", busy, timeout_err, run_count); end
    checks++; if (n_beats != b0) begin errors++; $display("FAIL to_no_beats: got %0d want 0", n_beats - b0); end
  endtask

  task automatic test_realign();
    b0 = n_beats; l0 = n_last;
    start_run(16'd0, 16'd8, 16'd3, 0);
    checks++; if ({timeout_err, realign_err} !== 2'b00) begin errors++; $display("FAIL ra_err_clear: got %b want 00", {timeout_err, realign_err}); end
    drive_det(1'b1, 16'h01FE, beat(21));
    cyc(2);
    checks++; if ({m_tvalid, lock_pattern} !== {1'b1, 16'h01FE}) begin errors++; $display("FAIL ra_first_lock: tvalid=%b pat=%h", m_tvalid, lock_pattern); end
    drive_det(1'b1, 16'h03FC, beat(22));
    step();
    checks++; if ({m_tvalid, realign_err, det_sc, locked, busy} !== 5'b01101) begin errors++; $display("FAIL ra_drop: tvalid,err,sc,locked,busy=%b want 01101", {m_tvalid, realign_err, det_sc, locked, busy}); end
    // Timeout 0 means SEARCH waits indefinitely.
    drive_det(1'b1, 16'h0000, beat(0));
    cyc(41);
    checks++; if ({busy, timeout_err} !== 2'b10) begin errors++; $display("FAIL ra_no_timeout: busy,err=%b want 10", {busy, timeout_err}); end
    drive_det(1'b1, 16'h03FC, beat(23));
    step();
    checks++; if ({locked, lock_pattern, m_tdata} !== {1'b1, 16'h03FC, beat(23)}) begin errors++; $display("FAIL ra_relock: locked=%b pat=%h", locked, lock_pattern); end
    drive_det(1'b1, 16'h03FC, beat(24));
    step();
    drive_det(1'b1, 16'h03FC, beat(25));
    step();
    checks++; if ({m_tlast, m_tdata} !== {1'b1, beat(25)}) begin errors++; $display("FAIL ra_last: tlast=%b data=%h", m_tlast, m_tdata); end
    drive_det(1'b0, 16'h0, beat(0));
    step();
    checks++; if ({realign_err, run_count} !== {1'b1, 16'd3}) begin errors++; $display("FAIL ra_done: err=%b run_count=%0d want 1 3", realign_err, run_count); end
    checks++; if ((n_beats - b0) != 4 || (n_last - l0) != 1) begin errors++; $display("FAIL ra_beat_total: beats=%0d lasts=%0d want 4 1", n_beats - b0, n_last - l0); end
  endtask

  task automatic test_abort();
    b0 = n_beats; l0 = n_last;
    start_run(16'd0, 16'd8, 16'd5, 0);
    drive_det(1'b1, 16'h01FE, beat(31));
    cyc(2);
    drive_det(1'b1, 16'h01FE, beat(32));
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if ({m_tvalid, det_sc, busy, locked} !== 4'b0100) begin errors++; $display("FAIL abort_now: tvalid,sc,busy,locked=%b want 0100", {m_tvalid, det_sc, busy, locked}); end
    drive_det(1'b1, 16'h01FE, beat(33));
    cyc(3);
    checks++; if ((n_beats - b0) != 1 || n_last != l0 || run_count !== 16'd3) begin errors++; $display("FAIL abort_after: beats=%0d lasts=%0d run_count=%0d want 1 0 3", n_beats - b0, n_last - l0, run_count); end
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checks++; if ({busy, det_sc} !== 2'b00) begin errors++; $display("FAIL abort_beats_start: busy,sc=%b want 00", {busy, det_sc}); end
    drive_det(1'b0, 16'h0, beat(0));
  endtask

  task automatic test_async_reset();
    start_run(16'd0, 16'd8, 16'd4, 0);
    drive_det(1'b1, 16'h01FE, beat(41));
    cyc(2);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({det_sc, det_mon_len, det_pre_len, m_tdata, m_tvalid, m_tlast, busy, locked, lock_pattern, timeout_err, realign_err, run_count} !== '0) begin
      errors++; $display("FAIL arst_clear: locked=%b tvalid=%b data=%h run_count=%0d", locked, m_tvalid, m_tdata, run_count); end
    step();
    rst_n = 1'b1;
    start_run(16'd2, 16'd8, 16'd1, 0);
    checks++; if ({det_sc, busy, run_count} !== {2'b11, 16'd0}) begin errors++; $display("FAIL arst_restart: sc,busy=%b run_count=%0d", {det_sc, busy}, run_count); end
    drive_det(1'b1, 16'h01FE, beat(51));
    cyc(3);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL arst_monitor: tvalid=%b want 0", m_tvalid); end
    step();
    checks++; if ({m_tvalid, m_tlast, det_sc, locked, m_tdata} !== {4'b1110, beat(51)}) begin errors++; $display("FAIL arst_single_beat: tvalid,tlast,sc,locked=%b", {m_tvalid, m_tlast, det_sc, locked}); end
    drive_det(1'b0, 16'h0, beat(0));
    step();
    checks++; if ({busy, run_count} !== {1'b0, 16'd1}) begin errors++; $display("FAIL arst_done: busy=%b run_count=%0d want 0 1", busy, run_count); end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_no_monitor();
    test_timeout();
    test_realign();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
